// File: rtl/ref_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ref_round_scheduler
// Description : A retention timer launches each refresh round. The round
//               visits every bank once, and each bank refresh is arbitrated
//               against user accesses with a bounded deferral.
// Revision    : 1.0 - initial release
// ============================================================================
module ref_round_scheduler #(
    parameter  int NUM_BANKS  = 8,
    parameter  int RET_CYCLES = 1000,
    parameter  int DEFER_MAX  = 16,
    localparam int BW         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          user_req_i,
    input  logic [BW-1:0] user_bank_i,
    input  logic          ref_done_i,
    output logic          ref_req_o,
    output logic [BW-1:0] ref_bank_o,
    output logic          user_stall_o,
    output logic          round_done_o,
    output logic          overrun_o
);

    localparam int TW = (RET_CYCLES > 1) ? $clog2(RET_CYCLES) : 1;
    localparam int DW = $clog2(DEFER_MAX + 1);

    localparam logic [TW-1:0] TMR_LAST  = TW'(RET_CYCLES - 1);
    localparam logic [BW-1:0] BANK_LAST = BW'(NUM_BANKS - 1);
    localparam logic [DW-1:0] DEFER_TOP = DW'(DEFER_MAX);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [TW-1:0] tmr;
    logic [BW-1:0] bank;
    logic [BW-1:0] bank_nx;
    logic [DW-1:0] defer;
    logic [DW-1:0] defer_nx;
    logic          launch;
    logic          conflict;
    logic          urgent;
    logic          last_bank;
    logic          ref_req_nx;
    logic          round_done_nx;
    logic          overrun_nx;

    always_comb begin
        launch    = en_i && (tmr == TMR_LAST);
        conflict  = user_req_i && (user_bank_i == bank);
        urgent    = (defer == DEFER_TOP);
        last_bank = (bank == BANK_LAST);
    end

    // The timer keeps running through a round so round launches stay on a
    // fixed RET_CYCLES grid; it only pauses while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr <= '0;
        end else if (en_i) begin
            tmr <= launch ? '0 : tmr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            bank  <= '0;
            defer <= '0;
        end else begin
            state <= state_nx;
            bank  <= bank_nx;
            defer <= defer_nx;
        end
    end

    always_comb begin
        state_nx = state;
        bank_nx  = bank;
        defer_nx = defer;
        case (state)
            S_IDLE: begin
                if (launch) begin
                    state_nx = S_ISSUE;
                    bank_nx  = '0;
                    defer_nx = '0;
                end
            end
            S_ISSUE: begin
                if (!conflict || urgent) begin
                    state_nx = S_WAIT;
                end else begin
                    defer_nx = defer + 1'b1;
                end
            end
            S_WAIT: begin
                if (ref_done_i) begin
                    if (last_bank) begin
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_ISSUE;
                        bank_nx  = bank + 1'b1;
                        defer_nx = '0;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Stall is a function of registered state only so user logic never sees
    // a combinational loop through user_req_i.
    always_comb begin
        ref_req_nx    = (state_nx == S_WAIT);
        round_done_nx = (state == S_WAIT) && ref_done_i && last_bank;
        overrun_nx    = overrun_o || (launch && (state != S_IDLE));
        user_stall_o  = (state == S_WAIT) || ((state == S_ISSUE) && urgent);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_req_o    <= 1'b0;
            round_done_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            ref_req_o    <= ref_req_nx;
            round_done_o <= round_done_nx;
            overrun_o    <= overrun_nx;
        end
    end

    assign ref_bank_o = bank;

endmodule
`default_nettype wire

// File: tb/tb_ref_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ref_round_scheduler
// Description : Randomized self-checking bench with a round-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ref_round_scheduler;

    localparam int NB  = 8;
    localparam int RET = 50;
    localparam int DMX = 4;

    logic       clk;
    logic       rst;
    logic       en_i;
    logic       user_req_i;
    logic [2:0] user_bank_i;
    logic       ref_done_i;
    logic       ref_req_o;
    logic [2:0] ref_bank_o;
    logic       user_stall_o;
    logic       round_done_o;
    logic       overrun_o;

    int checks;
    int errors;

    // Reference model: round progress as plain integers.
    int m_ticks;      // enabled cycles since reset, modulo RET
    bit m_active;     // a round is in progress
    bit m_handed;     // current bank handed to the refresh engine
    int m_bank;       // bank the round is working on
    int m_waited;     // conflicted cycles spent on this bank
    bit m_fin;        // round finished on the last edge
    bit m_ovr;

    ref_round_scheduler #(
        .NUM_BANKS (NB),
        .RET_CYCLES(RET),
        .DEFER_MAX (DMX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .user_req_i  (user_req_i),
        .user_bank_i (user_bank_i),
        .ref_done_i  (ref_done_i),
        .ref_req_o   (ref_req_o),
        .ref_bank_o  (ref_bank_o),
        .user_stall_o(user_stall_o),
        .round_done_o(round_done_o),
        .overrun_o   (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_ticks  = 0;
        m_active = 0;
        m_handed = 0;
        m_bank   = 0;
        m_waited = 0;
        m_fin    = 0;
        m_ovr    = 0;
    endtask

    task automatic model_step();
        bit fire;
        if (rst) begin
            model_reset();
            return;
        end
        fire  = en_i && (m_ticks == RET - 1);
        if (en_i) m_ticks = (m_ticks + 1) % RET;
        m_fin = 0;
        if (!m_active) begin
            if (fire) begin
                m_active = 1;
                m_handed = 0;
                m_bank   = 0;
                m_waited = 0;
            end
        end else begin
            if (fire) m_ovr = 1;
            if (!m_handed) begin
                if (user_req_i && int'(user_bank_i) == m_bank && m_waited < DMX)
                    m_waited++;
                else
                    m_handed = 1;
            end else if (ref_done_i) begin
                if (m_bank == NB - 1) begin
                    m_active = 0;
                    m_fin    = 1;
                end else begin
                    m_bank++;
                    m_waited = 0;
                    m_handed = 0;
                end
            end
        end
    endtask

    task automatic check_one(string tag, int got, int exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_one("ref_req",    int'(ref_req_o),    int'(m_active && m_handed));
        check_one("ref_bank",   int'(ref_bank_o),   m_bank);
        check_one("user_stall", int'(user_stall_o),
                  int'(m_active && (m_handed || m_waited == DMX)));
        check_one("round_done", int'(round_done_o), int'(m_fin));
        check_one("overrun",    int'(overrun_o),    int'(m_ovr));
    endtask

    // Called at a negedge: drive, clock, update model, check at next negedge.
    task automatic tick(input bit r, input bit e, input bit ur, input int ub, input bit d);
        rst         = r;
        en_i        = e;
        user_req_i  = ur;
        user_bank_i = 3'(ub);
        ref_done_i  = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int n;
        bit e, ur, d, r;
        int ub;
        checks = 0;
        errors = 0;
        rst = 1'b1; en_i = 1'b0; user_req_i = 1'b0; user_bank_i = '0; ref_done_i = 1'b0;
        model_reset();
        @(negedge clk);
        repeat (3) tick(1, 1, 0, 0, 1);

        // First round launch latency from reset release.
        n = 0;
        while (!ref_req_o && n < 200) begin
            tick(0, 1, 0, 0, 0);
            n++;
        end
        check_one("first_req_latency", n, RET + 1);

        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 700; c++) begin
                r  = 0;
                e  = 1;
                ur = 0;
                ub = $urandom_range(0, NB - 1);
                d  = 0;
                case (p)
                    0: d = ($urandom_range(0, 2) == 0);
                    1: begin
                        ur = ($urandom_range(0, 3) != 0);
                        ub = $urandom_range(0, 2);
                        d  = ($urandom_range(0, 1) == 0);
                    end
                    2: begin
                        e  = ($urandom_range(0, 3) != 0) && (c % 200 < 150);
                        ur = ($urandom_range(0, 1) == 0);
                        d  = ($urandom_range(0, 2) == 0);
                    end
                    3: begin
                        ur = ($urandom_range(0, 2) == 0);
                        d  = ($urandom_range(0, 39) == 0);
                    end
                    default: begin
                        r  = ($urandom_range(0, 99) == 0);
                        ur = ($urandom_range(0, 1) == 0);
                        ub = $urandom_range(0, 1);
                        d  = ($urandom_range(0, 3) == 0);
                    end
                endcase
                tick(r, e, ur, ub, d);
            end
        end

        // Reset while bank 6 is being refreshed, then re-measure launch.
        tick(1, 1, 0, 0, 0);
        n = 0;
        while (!(ref_req_o && ref_bank_o == 3'd6) && n < 300) begin
            tick(0, 1, 0, 0, ref_req_o);
            n++;
        end
        check_one("reach_bank6", int'(n < 300), 1);
        tick(1, 1, 0, 0, 0);
        check_one("rst_req_low",  int'(ref_req_o),  0);
        check_one("rst_bank_zero", int'(ref_bank_o), 0);
        n = 0;
        while (!ref_req_o && n < 200) begin
            tick(0, 1, 0, 0, 0);
            n++;
        end
        check_one("relaunch_latency", n, RET + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
